// File: rtl/a2d_pkg.sv
// Shared types and helpers for the ADC128S conversion scheduler.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package a2d_pkg;

  typedef enum logic [2:0] {IDLE, CMD, W1, GAPS, RD, W2} a2d_state_t;

  // ADC128S input channel of each sensor
  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  // Round-robin slot -> ADC channel
  function automatic logic [2:0] idx2chnl(input logic [1:0] idx);
    logic [2:0] ch;
    ch = CH_LFT;
    unique case (idx)
      2'd0: ch = CH_LFT;
      2'd1: ch = CH_RGHT;
      2'd2: ch = CH_STEER;
      2'd3: ch = CH_BATT;
    endcase
    return ch;
  endfunction

  // Control word: channel select lives in bits [13:11]
  function automatic logic [15:0] mk_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_timer.sv
// Loadable down-counter used as the sample-interval timer and the SPI watchdog.
// Latency: zero_o is registered state; a load is visible the cycle after ld_i.
// Backpressure: none; en_i freezes the count, ld_i has priority over en_i.
//
// Ports: clk_i, rst_i (sync, active high), ld_i/ld_val_i (reload),
//        en_i (decrement enable), zero_o (count has reached zero).
module a2d_timer #(
  parameter int            W       = 16,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic         en_i,
  input  logic [W-1:0] ld_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an expired count stays visible until reloaded
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)
      cnt_d = ld_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/a2d_sched.sv
// Round-robin ADC128S scheduler: lft, rght, steer, batt; two SPI transactions per
//   conversion (channel out in the first, result back in the second).
// Latency: start to vld = two SPI transactions + GAP + 4 cycles.
// Backpressure: none; nxt during a conversion is dropped, watchdog abandons a stuck SPI.
//
// Ports: clk_i, rst_i (sync, active high), en_i, nxt_i,
//        spi_wrt_o/spi_cmd_o -> SPI master, spi_done_i/spi_rd_i <- SPI master,
//        lft_ld_o, rght_ld_o, steer_pot_o, batt_o (held results),
//        vld_o, round_done_o (pulses), tmo_err_o (sticky).
module a2d_sched
  import a2d_pkg::*;
#(
  parameter logic [15:0] INTERVAL = 16'd4096,
  parameter logic [15:0] TIMEOUT  = 16'd2048,
  parameter logic [3:0]  GAP      = 4'd2      // must be at least 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        nxt_i,
  output logic        spi_wrt_o,
  output logic [15:0] spi_cmd_o,
  input  logic        spi_done_i,
  input  logic [15:0] spi_rd_i,
  output logic [11:0] lft_ld_o,
  output logic [11:0] rght_ld_o,
  output logic [11:0] steer_pot_o,
  output logic [11:0] batt_o,
  output logic        vld_o,
  output logic        round_done_o,
  output logic        tmo_err_o
);

  a2d_state_t  state_q;
  logic [1:0]  idx_q;
  logic [3:0]  gap_q;
  logic        spi_wrt_q, vld_q, round_done_q, tmo_err_q;
  logic [15:0] spi_cmd_q;
  logic [11:0] lft_q, rght_q, steer_q, batt_q;

  logic start, waiting, tmo, ivl_zero, wdog_zero;
  logic unused_rd_hi;

  assign unused_rd_hi = ^spi_rd_i[15:12];

  assign waiting = (state_q == W1) || (state_q == W2);
  // Timer expiry and nxt in the same cycle collapse into one start
  assign start   = (state_q == IDLE) && en_i && (ivl_zero || nxt_i);
  // A done arriving on the last watchdog cycle still wins
  assign tmo     = waiting && wdog_zero && !spi_done_i;

  // Interval timer: counts only while idle and enabled, holds otherwise
  a2d_timer #(.W(16), .RST_VAL(INTERVAL - 16'd1)) u_ivl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ld_i     (start),
    .en_i     ((state_q == IDLE) && en_i),
    .ld_val_i (INTERVAL - 16'd1),
    .zero_o   (ivl_zero)
  );

  // Watchdog: rearmed in the spi_wrt cycle of each transaction
  a2d_timer #(.W(16), .RST_VAL(TIMEOUT - 16'd1)) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ld_i     ((state_q == CMD) || (state_q == RD)),
    .en_i     (waiting),
    .ld_val_i (TIMEOUT - 16'd1),
    .zero_o   (wdog_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      gap_q        <= 4'd0;
      spi_wrt_q    <= 1'b0;
      spi_cmd_q    <= 16'h0000;
      vld_q        <= 1'b0;
      round_done_q <= 1'b0;
      tmo_err_q    <= 1'b0;
      lft_q        <= 12'h000;
      rght_q       <= 12'h000;
      steer_q      <= 12'h000;
      batt_q       <= 12'h000;
    end else begin
      spi_wrt_q    <= 1'b0;
      vld_q        <= 1'b0;
      round_done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          state_q   <= CMD;
          spi_wrt_q <= 1'b1;
          spi_cmd_q <= mk_cmd(idx2chnl(idx_q));
        end
        CMD: state_q <= W1;
        W1: begin
          // first read-back belongs to the previous channel and is dropped
          if (spi_done_i) begin
            state_q <= GAPS;
            gap_q   <= GAP - 4'd1;
          end else if (tmo) begin
            state_q   <= IDLE;
            tmo_err_q <= 1'b1;
            idx_q     <= idx_q + 2'd1;
          end
        end
        GAPS: begin
          if (gap_q == 4'd0) begin
            state_q   <= RD;
            spi_wrt_q <= 1'b1;   // same spi_cmd word as the first transaction
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        RD: state_q <= W2;
        W2: begin
          if (spi_done_i) begin
            unique case (idx_q)
              2'd0: lft_q   <= spi_rd_i[11:0];
              2'd1: rght_q  <= spi_rd_i[11:0];
              2'd2: steer_q <= spi_rd_i[11:0];
              2'd3: batt_q  <= spi_rd_i[11:0];
            endcase
            vld_q        <= 1'b1;
            round_done_q <= (idx_q == 2'd3);
            idx_q        <= idx_q + 2'd1;
            state_q      <= IDLE;
          end else if (tmo) begin
            state_q   <= IDLE;
            tmo_err_q <= 1'b1;
            idx_q     <= idx_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_wrt_o    = spi_wrt_q;
  assign spi_cmd_o    = spi_cmd_q;
  assign lft_ld_o     = lft_q;
  assign rght_ld_o    = rght_q;
  assign steer_pot_o  = steer_q;
  assign batt_o       = batt_q;
  assign vld_o        = vld_q;
  assign round_done_o = round_done_q;
  assign tmo_err_o    = tmo_err_q;

endmodule
